// File: rtl/mostra_sequencia_pkg.sv
// mostra_sequencia_pkg: shared game constants and presenter state encoding
package mostra_sequencia_pkg;
    localparam int LED_W  = 16;
    localparam int ADDR_W = 4;
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        ESPERA  = 3'd2,
        ACESO   = 3'd3,
        APAGADO = 3'd4,
        FIM     = 3'd5
    } estado_t;
endpackage

// File: rtl/mostra_sequencia_if.sv
// mostra_sequencia_if: control, ROM and display signals of the sequence presenter
interface mostra_sequencia_if;
    import mostra_sequencia_pkg::*;
    logic              iniciar;
    logic [ADDR_W-1:0] nivel;
    logic [LED_W-1:0]  rom_dado;
    logic [ADDR_W-1:0] rom_endereco;
    logic [LED_W-1:0]  leds;
    logic              ocupado;
    logic              pronto;
    logic [2:0]        db_estado;
    modport master (
        output iniciar, nivel, rom_dado,
        input  rom_endereco, leds, ocupado, pronto, db_estado
    );
    modport slave (
        input  iniciar, nivel, rom_dado,
        output rom_endereco, leds, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/mostra_sequencia_contador_m.sv
// contador_m: modulo-M phase timer with synchronous clear and terminal flag
module contador_m #(
    parameter int M = 4,
    parameter int N = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);
    logic [N-1:0] r_q;
    assign fim = r_q == N'(M - 1);
    // count while enabled, wrap at M-1, clear on reset or phase change
    always_ff @(posedge clock) begin
        if (reset || zera_s) r_q <= '0;
        else if (conta) r_q <= fim ? '0 : r_q + 1'b1;
    end
endmodule

// File: rtl/mostra_sequencia.sv
// mostra_sequencia: plays ROM entries 0..nivel on the LEDs with timed on/off phases
module mostra_sequencia
    import mostra_sequencia_pkg::*;
#(
    parameter int ON_CYCLES  = 1000,
    parameter int OFF_CYCLES = 500,
    parameter int TIMER_W    = 10
) (
    input  logic clock,
    input  logic reset,
    mostra_sequencia_if.slave bus
);
    estado_t           r_estado, w_next;
    logic [ADDR_W-1:0] r_idx, r_nivel;
    logic [LED_W-1:0]  r_leds;
    logic              w_fim_on, w_fim_off;
    logic              w_aceso, w_apagado, w_inicia, w_ultimo;

    assign w_aceso   = r_estado == ACESO;
    assign w_apagado = r_estado == APAGADO;
    assign w_inicia  = r_estado == OCIOSO && bus.iniciar;
    assign w_ultimo  = r_idx == r_nivel;

    contador_m #(.M(ON_CYCLES), .N(TIMER_W)) u_timer_on (
        .clock(clock), .reset(reset), .zera_s(!w_aceso), .conta(w_aceso), .fim(w_fim_on)
    );
    contador_m #(.M(OFF_CYCLES), .N(TIMER_W)) u_timer_off (
        .clock(clock), .reset(reset), .zera_s(!w_apagado), .conta(w_apagado), .fim(w_fim_off)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) r_estado <= OCIOSO;
        else r_estado <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = OCIOSO;
        case (r_estado)
            OCIOSO:  w_next = bus.iniciar ? BUSCA : OCIOSO;
            BUSCA:   w_next = ESPERA;
            ESPERA:  w_next = ACESO;
            ACESO:   w_next = w_fim_on ? APAGADO : ACESO;
            APAGADO: w_next = !w_fim_off ? APAGADO : (w_ultimo ? FIM : BUSCA);
            default: w_next = OCIOSO;
        endcase
    end

    // index doubles as ROM address; it only moves on start and between entries
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx   <= '0;
            r_nivel <= '0;
            r_leds  <= '0;
        end else begin
            if (w_inicia) begin
                r_idx   <= '0;
                r_nivel <= bus.nivel;
            end else if (w_apagado && w_fim_off && !w_ultimo) begin
                r_idx <= r_idx + 1'b1;
            end
            r_leds <= (r_estado == ESPERA) ? bus.rom_dado : (w_aceso && !w_fim_on) ? r_leds : '0;
        end
    end

    assign bus.rom_endereco = r_idx;
    assign bus.leds         = r_leds;
    assign bus.ocupado      = r_estado != OCIOSO;
    assign bus.pronto       = r_estado == FIM;
    assign bus.db_estado    = r_estado;
endmodule

// File: tb/tb_mostra_sequencia.sv
// tb_mostra_sequencia: randomized self-checking bench against a cycle-table model
module tb_mostra_sequencia;
    localparam int ON  = 4;
    localparam int OFF = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mostra_sequencia_if bus();
    mostra_sequencia #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .TIMER_W(3)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    logic [15:0] rom [16];
    always @(posedge clock) bus.rom_dado <= rom[bus.rom_endereco];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] leds;
        logic [3:0]  addr;
        logic [2:0]  est;
        logic        pronto;
    } step_t;
    step_t exp_q[$];

    function automatic step_t mk(input logic [15:0] l, input int a, input int e, input logic p);
        step_t s;
        s.leds = l; s.addr = 4'(a); s.est = 3'(e); s.pronto = p;
        return s;
    endfunction

    // expected per-cycle behaviour from the start edge: fetch, wait, lit, dark per entry, then done
    task automatic build(input int n);
        exp_q.delete();
        for (int i = 0; i <= n; i++) begin
            exp_q.push_back(mk(16'h0, i, 1, 1'b0));
            exp_q.push_back(mk(16'h0, i, 2, 1'b0));
            repeat (ON) exp_q.push_back(mk(rom[i], i, 3, 1'b0));
            repeat (OFF) exp_q.push_back(mk(16'h0, i, 4, 1'b0));
        end
        exp_q.push_back(mk(16'h0, n, 5, 1'b1));
    endtask

    task automatic cmp_step(input int c);
        check($sformatf("leds[%0d]", c), bus.leds, exp_q[c].leds);
        check($sformatf("addr[%0d]", c), bus.rom_endereco, exp_q[c].addr);
        check($sformatf("estado[%0d]", c), bus.db_estado, exp_q[c].est);
        check($sformatf("pronto[%0d]", c), bus.pronto, exp_q[c].pronto);
        check($sformatf("ocupado[%0d]", c), bus.ocupado, 1);
    endtask

    task automatic run_seq(input int n, input int inject);
        build(n);
        @(negedge clock);
        bus.iniciar = 1'b1;
        bus.nivel   = 4'(n);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clock);
            bus.iniciar = (c == inject);
            if (c == inject) bus.nivel = 4'd7;
            cmp_step(c);
        end
        @(negedge clock);
        check("ocupado_idle", bus.ocupado, 0);
        check("pronto_idle", bus.pronto, 0);
        check("leds_idle", bus.leds, 0);
        check("estado_idle", bus.db_estado, 0);
    endtask

    initial begin
        int p1, p2, np, lows, n;
        bus.iniciar = 1'b0;
        bus.nivel   = 4'd0;
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
        repeat (2) @(negedge clock);
        check("rst_leds", bus.leds, 0);
        check("rst_addr", bus.rom_endereco, 0);
        check("rst_ocupado", bus.ocupado, 0);
        check("rst_pronto", bus.pronto, 0);
        check("rst_estado", bus.db_estado, 0);
        reset = 1'b0;

        rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0004;
        build(2);
        @(negedge clock);
        bus.iniciar = 1'b1;
        bus.nivel   = 4'd2;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            bus.iniciar = 1'b0;
            cmp_step(c);
        end
        reset = 1'b1;
        @(negedge clock);
        check("midrst_leds", bus.leds, 0);
        check("midrst_ocupado", bus.ocupado, 0);
        check("midrst_estado", bus.db_estado, 0);
        check("midrst_pronto", bus.pronto, 0);
        reset = 1'b0;

        run_seq(0, -1);
        run_seq(2, -1);
        run_seq(2, 5);
        run_seq(2, 12);
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
        run_seq(15, -1);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            n = int'($urandom_range(0, 15));
            run_seq(n, int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 6)) : -1);
        end

        rom[0] = 16'h8000;
        p1 = -1; p2 = -1; np = 0; lows = 0;
        @(negedge clock);
        bus.nivel   = 4'd0;
        bus.iniciar = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.pronto) begin
                np++;
                if (p1 < 0) p1 = c;
                else if (p2 < 0) p2 = c;
            end
            if (p1 >= 0 && p2 < 0 && !bus.ocupado) lows++;
        end
        bus.iniciar = 1'b0;
        check("held_pulses", 32'(np >= 2), 1);
        check("held_spacing", 32'(p2 - p1), 1 + 2 + ON + OFF + 1);
        check("held_idle_gap", 32'(lows), 1);
        n = 0;
        while (bus.ocupado && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("held_drain", bus.ocupado, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mostra_sequencia.md
Name: mostra_sequencia

Overview:
- Presenter (transmitter) side of the memory game: plays the stored button sequence to the player on 16 one-hot LEDs before the player repeats it on the buttons.
- On a start request, reads ROM entries 0..nivel in order. Each entry is lit for ON_CYCLES and then blanked for OFF_CYCLES.
- Pulses `pronto` when done so the game FSM can enable the jogada path.
- Sits beside the jogada datapath and drives the address of its own 16x16 sync ROM instance.

Parameters:
- ON_CYCLES, 1000, clock cycles each entry is shown on `leds`; must be >= 1.
- OFF_CYCLES, 500, clock cycles `leds` is all-zero after each entry; must be >= 1.
- TIMER_W, 10, timer width; must satisfy 2^TIMER_W >= max(ON_CYCLES, OFF_CYCLES).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- iniciar  in  1  start request, level-sampled only in OCIOSO.
- nivel  in  4  index of last entry to show (0..15); sampled when start is accepted.
- rom_dado  in  16  data from sync ROM, valid one cycle after `rom_endereco` is presented.
- rom_endereco  out  4  ROM address (entry index).
- leds  out  16  displayed pattern, registered.
- ocupado  out  1  high in every state except OCIOSO.
- pronto  out  1  one-cycle pulse at the end of the sequence.
- db_estado  out  3  state encoding, for debug.

Behaviour:
- Reset (synchronous) forces:
  - state OCIOSO;
  - `leds`=0, `rom_endereco`=0, `ocupado`=0, `pronto`=0;
  - timer=0 and latched nivel=0.
- Reset wins over every other input in the same cycle, including mid-sequence: the sequence aborts and LEDs go dark on the next edge.
- States and encoding:
  - OCIOSO=0, BUSCA=1, ESPERA=2, ACESO=3, APAGADO=4, FIM=5.
  - Unused codes go to OCIOSO.
- OCIOSO:
  - `leds`=0.
  - If `iniciar`=1 at edge k: latch nivel, index=0, go to BUSCA.
- BUSCA (1 cycle): `rom_endereco`=index; go to ESPERA.
- ESPERA (1 cycle):
  - ROM output becomes valid.
  - At the exiting edge: `leds` <= `rom_dado`, timer cleared, go to ACESO.
- ACESO:
  - `leds` holds the pattern for exactly ON_CYCLES cycles.
  - Timer counts; when timer==ON_CYCLES-1: `leds` <= 0, timer cleared, go to APAGADO.
- APAGADO:
  - `leds`=0 for exactly OFF_CYCLES cycles.
  - At the end, if index==latched nivel: go to FIM.
  - Otherwise index+1 and go to BUSCA.
- FIM: `pronto`=1 for this single cycle; go to OCIOSO.
- Latency:
  - First pattern appears on `leds` in the cycle after edge k+2.
  - Period per entry is 2+ON_CYCLES+OFF_CYCLES cycles.
  - `pronto` follows the last blank period immediately.
- Boundaries:
  - nivel=0 shows exactly one entry.
  - nivel=15 shows all 16 entries. The index never wraps and no 17th read occurs.
  - `iniciar` while `ocupado`=1 is ignored; it is not queued.
  - `iniciar` held high through FIM restarts in the cycle after FIM (OCIOSO samples it).
  - Changes to `nivel` while `ocupado`=1 have no effect.
  - `rom_dado`=0 is displayed as an all-dark ON period; there is no special handling.
- `rom_endereco` holds its last value outside BUSCA/ESPERA. It is don't-care to the consumer but must be deterministic.

Decomposition:
- Shared game package (`genius_pkg`) holds:
  - state encoding constants;
  - LED/button width constant (16);
  - ROM address width (4).
- One natural sub-module: the existing `contador_m` as the phase timer, with zera_s driven by the FSM and `fim` used as the terminal flag. This needs two instances, or one instance whose modulus is selected by phase.
- FSM and index register stay in this module.

Test Plan:
- Reset mid-ACESO (ON=4, OFF=2): assert reset during a lit entry -> next edge `leds`=0, `ocupado`=0, db_estado=0, no `pronto`.
- nivel=0, ROM[0]=16'h0001, ON=4, OFF=2, start at edge k:
  - `leds`=16'h0001 for cycles k+3..k+6, then 0;
  - `pronto` high exactly in cycle k+9;
  - ROM read only at address 0.
- nivel=2, ROM[0..2]=0001,0002,0004:
  - `leds` sequence 0001,0,0002,0,0004,0, each with exact ON/OFF widths;
  - `rom_endereco` 0,1,2;
  - a single `pronto`.
- nivel=15, full sequence: 16 lit periods, max `rom_endereco`=15, no wrap to 0 before `pronto`.
- `iniciar` pulsed and `nivel` changed from 2 to 7 while `ocupado`: no restart, still exactly 3 entries shown.
- `iniciar` held high continuously with nivel=0: back-to-back sequences, `pronto` pulses spaced exactly 1+2+ON+OFF+1 cycles apart, `ocupado` low for one cycle between them.
